// File: rtl/eflash_pkg.sv
// Shared types and safe pin levels for the eFlash column sequencer.
package eflash_pkg;

    typedef enum logic [2:0] {
        MODE_ERASE = 3'b001,
        MODE_PROG  = 3'b010,
        MODE_READ  = 3'b011,
        MODE_PAR   = 3'b101,
        MODE_RBR   = 3'b110
    } pim_mode_e;

    typedef enum logic [2:0] {
        S_IDLE, S_PULSE, S_PRE, S_EVAL, S_HOLD, S_DIS, S_DONE
    } col_state_e;

    localparam logic SAFE_DUMH  = 1'b0;
    localparam logic SAFE_PRECB = 1'b1;
    localparam logic SAFE_DISC  = 1'b0;

    // Modes that run the precharge/evaluate/hold/discharge phase train.
    function automatic logic is_analog(input logic [2:0] mode);
        return (mode == MODE_READ) || (mode == MODE_PAR) || (mode == MODE_RBR);
    endfunction

endpackage

// File: rtl/eflash_col_pattern.sv
// Combinational pin pattern for one sequencer cycle: maps mode, state and
// phase index onto the DUMH/PRECB/DISC levels.
module eflash_col_pattern
    import eflash_pkg::*;
#(
    parameter int N_DUMH        = 256,
    parameter int N_PRECB       = 128,
    parameter int N_RGRP        = 8,
    parameter int COL_PER_PRECB = 4,
    parameter int COL_PER_DUMH  = 16,
    parameter int IN_BITS       = 2,
    localparam int RGW = $clog2(N_RGRP),
    localparam int CAW = $clog2(N_PRECB * COL_PER_PRECB)
) (
    input  logic [2:0]                       mode,
    input  col_state_e                       state,
    input  logic [IN_BITS-1:0]               eval_idx,
    input  logic [RGW-1:0]                   rg,
    input  logic [CAW-1:0]                   col_addr,
    input  logic [N_DUMH-1:0][IN_BITS-1:0]   in_data,
    output logic [N_DUMH-1:0]                dumh,
    output logic [N_PRECB-1:0]               precb,
    output logic [N_PRECB-1:0]               disc
);

    localparam int DW = $clog2(N_DUMH);
    localparam int PW = $clog2(N_PRECB);

    logic [DW-1:0] prog_idx;
    logic [PW-1:0] line_idx;

    // Truncation to DW bits gives the modulo-N_DUMH wrap of the program index.
    assign prog_idx = DW'(rg) + DW'(N_RGRP * (int'(col_addr) / COL_PER_DUMH));
    assign line_idx = PW'(int'(col_addr) / COL_PER_PRECB);

    always_comb begin
        // NOTE: every output gets a value before the case so no path can infer a latch.
        dumh  = {N_DUMH{SAFE_DUMH}};
        precb = {N_PRECB{SAFE_PRECB}};
        disc  = {N_PRECB{SAFE_DISC}};
        unique case (state)
            S_PULSE: begin
                if (mode == MODE_ERASE) begin
                    disc = '1;
                end else if (mode == MODE_PROG) begin
                    for (int i = 0; i < N_DUMH; i++) dumh[i] = (DW'(i) == prog_idx);
                    for (int j = 0; j < N_PRECB; j++) begin
                        precb[j] = (PW'(j) == line_idx);
                        disc[j]  = (PW'(j) == line_idx);
                    end
                end
            end
            S_PRE: if (is_analog(mode)) begin
                precb = '0;
                disc  = '1;
                for (int i = 0; i < N_DUMH; i++)
                    dumh[i] = (mode == MODE_PAR) || (RGW'(i % N_RGRP) == rg);
            end
            S_EVAL: if (is_analog(mode)) begin
                disc = '1;
                for (int i = 0; i < N_DUMH; i++) begin
                    if (mode == MODE_READ)
                        dumh[i] = (RGW'(i % N_RGRP) == rg);
                    else if (mode == MODE_PAR)
                        dumh[i] = (eval_idx < in_data[i]);
                    else
                        dumh[i] = (RGW'(i % N_RGRP) == rg) && (eval_idx < in_data[i / N_RGRP]);
                end
            end
            S_HOLD: if (is_analog(mode)) disc = '1;
            default: ;
        endcase
    end

endmodule

// File: rtl/eflash_col_seq.sv
// Self-sequencing eFlash column driver: FSM, phase counter and registered pins.
// Define EFLASH_COL_ABORT_EN to add the abort_i early-termination input.
module eflash_col_seq
    import eflash_pkg::*;
#(
    parameter int N_DUMH        = 256,
    parameter int N_PRECB       = 128,
    parameter int N_RGRP        = 8,
    parameter int COL_PER_PRECB = 4,
    parameter int COL_PER_DUMH  = 16,
    parameter int IN_BITS       = 2,
    parameter int PRE_CYC       = 3,
    parameter int HOLD_CYC      = 2,
    parameter int DIS_CYC       = 3,
    localparam int RAW = $clog2(N_RGRP) + 4,
    localparam int CAW = $clog2(N_PRECB * COL_PER_PRECB)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [2:0]                       mode_i,
    input  logic [RAW-1:0]                   row_addr_i,
    input  logic [CAW-1:0]                   col_addr_i,
    input  logic [15:0]                      pulse_cyc_i,
    input  logic [N_DUMH-1:0][IN_BITS-1:0]   input_data_i,
`ifdef EFLASH_COL_ABORT_EN
    input  logic                             abort_i,
`endif
    output logic                             busy_o,
    output logic                             done_o,
    output logic [N_DUMH-1:0]                DUMH_o,
    output logic [N_PRECB-1:0]               PRECB_o,
    output logic [N_PRECB-1:0]               DISC_o
);

    localparam int RGW      = $clog2(N_RGRP);
    localparam int EVAL_CYC = (1 << IN_BITS) - 1;

    col_state_e                      state_q, state_d;
    logic [15:0]                     cnt_q, cnt_d, phase_len;
    logic                            phase_last, load, abort_hit;
    logic [2:0]                      mode_q;
    logic [RGW-1:0]                  rg_q;
    logic [CAW-1:0]                  col_q;
    logic [15:0]                     pulse_q;
    logic [N_DUMH-1:0][IN_BITS-1:0]  in_q;
    logic [N_DUMH-1:0]               dumh_c;
    logic [N_PRECB-1:0]              precb_c, disc_c;
    logic                            unused_row_bits;

    assign unused_row_bits = ^row_addr_i[3:0];

    // Phase successor with zero-length phases skipped; EVAL is never empty.
    function automatic col_state_e next_phase(input col_state_e s);
        next_phase = S_DONE;
        case (s)
            S_PRE:   next_phase = S_EVAL;
            S_EVAL:  next_phase = (HOLD_CYC > 0) ? S_HOLD : ((DIS_CYC > 0) ? S_DIS : S_DONE);
            S_HOLD:  next_phase = (DIS_CYC > 0) ? S_DIS : S_DONE;
            default: next_phase = S_DONE;
        endcase
    endfunction

`ifdef EFLASH_COL_ABORT_EN
    assign abort_hit = abort_i && (state_q inside {S_PULSE, S_PRE, S_EVAL, S_HOLD});
`else
    assign abort_hit = 1'b0;
`endif

    // Erase/program pulses last at least one cycle; no-op modes reuse PULSE for one cycle.
    always_comb begin
        unique case (state_q)
            S_PULSE: phase_len = ((mode_q == MODE_ERASE || mode_q == MODE_PROG) && pulse_q != '0)
                                 ? pulse_q : 16'd1;
            S_PRE:   phase_len = 16'(PRE_CYC);
            S_EVAL:  phase_len = 16'(EVAL_CYC);
            S_HOLD:  phase_len = 16'(HOLD_CYC);
            S_DIS:   phase_len = 16'(DIS_CYC);
            default: phase_len = 16'd1;
        endcase
    end

    assign phase_last = (cnt_q == phase_len - 16'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: if (start_i) begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = is_analog(mode_i) ? ((PRE_CYC > 0) ? S_PRE : S_EVAL) : S_PULSE;
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (abort_hit) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_PULSE || DIS_CYC == 0) ? S_DONE : S_DIS;
                end else if (phase_last) begin
                    cnt_d   = '0;
                    state_d = next_phase(state_q);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    eflash_col_pattern #(
        .N_DUMH        (N_DUMH),
        .N_PRECB       (N_PRECB),
        .N_RGRP        (N_RGRP),
        .COL_PER_PRECB (COL_PER_PRECB),
        .COL_PER_DUMH  (COL_PER_DUMH),
        .IN_BITS       (IN_BITS)
    ) u_pattern (
        .mode     (mode_q),
        .state    (state_q),
        .eval_idx (cnt_q[IN_BITS-1:0]),
        .rg       (rg_q),
        .col_addr (col_q),
        .in_data  (in_q),
        .dumh     (dumh_c),
        .precb    (precb_c),
        .disc     (disc_c)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            DUMH_o  <= {N_DUMH{SAFE_DUMH}};
            PRECB_o <= {N_PRECB{SAFE_PRECB}};
            DISC_o  <= {N_PRECB{SAFE_DISC}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            DUMH_o  <= dumh_c;
            PRECB_o <= precb_c;
            DISC_o  <= disc_c;
        end
    end

    // NOTE: the command registers carry no reset; they are only read outside IDLE/DONE, after a load.
    always_ff @(posedge clk_i) begin
        if (load) begin
            mode_q  <= mode_i;
            rg_q    <= row_addr_i[RAW-1:4];
            col_q   <= col_addr_i;
            pulse_q <= pulse_cyc_i;
            in_q    <= input_data_i;
        end
    end

    assign busy_o = !(state_q == S_IDLE || state_q == S_DONE);
    assign done_o = (state_q == S_DONE);

endmodule
